// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial transmitter for the framed single-bit link.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit per
// clock on o_sdata, with o_sframe marking every framed bit. Each frame is
// followed by one GAP cycle so the far-end deserializer always sees a frame
// gap of at least two cycles (GAP + the IDLE accept cycle).
//
// Optional feature: define SERIAL_TX_PARITY_EN to append one even-parity bit
// (XOR of all data bits) after the last data bit.
//
// Parameters:
//   WIDTH     data bits per frame (1..64)
//   MSB_FIRST 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_data    word to send, sampled on accept
//   i_valid   i_data valid
//   o_ready   word can be accepted this cycle
//   o_sdata   serial data (0 whenever o_sframe is low)
//   o_sframe  high while o_sdata carries a frame bit
//   o_busy    high from the cycle after accept until back in IDLE
module serial_tx #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sdata,
  output logic             o_sframe,
  output logic             o_busy
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sdata_nx, sframe_nx, busy_nx, ready_nx;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity, parity_nx;
`endif

  // Bit c of the transmit order: the word is held static and the counter
  // selects the bit, which avoids a degenerate shifter when WIDTH == 1.
  function automatic logic pick(input logic [WIDTH-1:0] d, input logic [CW-1:0] c);
    logic [WIDTH-1:0] t;
    if (MSB_FIRST) begin
      t    = d << c;
      pick = t[WIDTH-1];
    end else begin
      t    = d >> c;
      pick = t[0];
    end
  endfunction

  // Outputs are registered, so they are computed here from the next state.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = cnt;
    sdata_nx  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_nx = parity;
`endif
    case (state)
      IDLE: begin
        if (i_valid && o_ready) begin
          state_nx  = SHIFT;
          shreg_nx  = i_data;
          cnt_nx    = '0;
          sdata_nx  = pick(i_data, '0);
`ifdef SERIAL_TX_PARITY_EN
          parity_nx = ^i_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
          state_nx = PARITY;
          sdata_nx = parity;
`else
          state_nx = GAP;
`endif
        end else begin
          cnt_nx   = cnt + CW'(1);
          sdata_nx = pick(shreg, cnt + CW'(1));
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: state_nx = GAP;
`endif
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

`ifdef SERIAL_TX_PARITY_EN
    sframe_nx = (state_nx == SHIFT) || (state_nx == PARITY);
`else
    sframe_nx = (state_nx == SHIFT);
`endif
    busy_nx  = (state_nx != IDLE);
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      o_ready  <= 1'b1;
      o_sdata  <= 1'b0;
      o_sframe <= 1'b0;
      o_busy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      cnt      <= cnt_nx;
      o_ready  <= ready_nx;
      o_sdata  <= sdata_nx;
      o_sframe <= sframe_nx;
      o_busy   <= busy_nx;
`ifdef SERIAL_TX_PARITY_EN
      parity   <= parity_nx;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- scoreboard bench for serial_tx.
// Two instances share stimulus: index 0 is MSB-first, index 1 is LSB-first.
// The driver pushes the expected frame (bit list from the word) on each
// accept; a monitor collects framed bits and compares when the frame ends.
module tb_serial_tx;
  localparam int W = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [63:0] bits;
    int          n;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data;
  logic         valid;
  logic [1:0]   ready, sdata, sframe, busy;

  int n_chk  = 0;
  int n_fail = 0;

  frame_t exp_q0[$];
  frame_t exp_q1[$];

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready[0]), .o_sdata(sdata[0]), .o_sframe(sframe[0]), .o_busy(busy[0]));

  serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(ready[1]), .o_sdata(sdata[1]), .o_sframe(sframe[1]), .o_busy(busy[1]));

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the i-th transmitted bit is data bit (W-1-i) or i, then parity.
  function automatic frame_t model(input logic [W-1:0] d, input bit msb);
    frame_t f;
    f.bits = '0;
    for (int i = 0; i < W; i++)
      f.bits[i] = msb ? d[W-1-i] : d[i];
    f.n = W;
    if (P == 1) begin
      f.bits[W] = ^d;
      f.n       = W + 1;
    end
    return f;
  endfunction

  // Called just after a negedge; returns just after the negedge following the
  // accept edge, with i_valid low and i_data scrambled (mid-frame toggling).
  task automatic send(input logic [W-1:0] w, input int pre, output time acc_t);
    int wait_cyc = 0;
    acc_t = 0;
    repeat (pre) begin
      valid = 1'b0;
      data  = W'($urandom);
      @(negedge clk);
    end
    valid = 1'b1;
    data  = w;
    while (ready[0] !== 1'b1 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 100) begin
      check(1'b0, "accept_timeout", 64'(wait_cyc), 64'd100);
      valid = 1'b0;
      return;
    end
    exp_q0.push_back(model(w, 1'b1));
    exp_q1.push_back(model(w, 1'b0));
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    check({sframe, busy, ready} == 6'b11_11_00, "first_bit_latency",
          64'({sframe, busy, ready}), 64'b11_11_00);
    valid = 1'b0;
    data  = W'($urandom);
  endtask

  logic [63:0] col_bits[2];
  int          col_n[2];
  bit          gap_pend[2];

  initial begin
    time    t1, t2;
    frame_t e;
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    col_bits = '{64'd0, 64'd0};
    col_n    = '{0, 0};
    gap_pend = '{1'b0, 1'b0};

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          col_bits = '{64'd0, 64'd0};
          col_n    = '{0, 0};
          gap_pend = '{1'b0, 1'b0};
        end else begin
          for (int g = 0; g < 2; g++) begin
            if (gap_pend[g]) begin
              check(ready[g] && !busy[g], "idle_after_gap", 64'({ready[g], busy[g]}), 64'b10);
              gap_pend[g] = 1'b0;
            end
            if (sframe[g]) begin
              col_bits[g][col_n[g]] = sdata[g];
              col_n[g]++;
              if (col_n[g] > W + P) begin
                check(1'b0, "frame_too_long", 64'(col_n[g]), 64'(W + P));
                col_n[g]    = 0;
                col_bits[g] = '0;
              end
            end else begin
              check(sdata[g] === 1'b0, "sdata_outside_frame", 64'(sdata[g]), 64'd0);
              if (col_n[g] > 0) begin
                if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                  check(1'b0, "unexpected_frame", 64'(col_n[g]), 64'd0);
                end else begin
                  e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  check(col_n[g] == e.n, "frame_length", 64'(col_n[g]), 64'(e.n));
                  check(col_bits[g] == e.bits, "frame_bits", col_bits[g], e.bits);
                end
                check(busy[g] && !ready[g], "gap_cycle", 64'({busy[g], ready[g]}), 64'b10);
                gap_pend[g] = 1'b1;
                col_n[g]    = 0;
                col_bits[g] = '0;
              end
            end
          end
        end
      end
    join_none

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check({ready, sframe, sdata, busy} == 8'b11_00_00_00, "reset_values",
          64'({ready, sframe, sdata, busy}), 64'b11_00_00_00);
    rst_n = 1'b1;

    // Idle for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      check({ready, sframe, sdata, busy} == 8'b11_00_00_00, "idle_outputs",
            64'({ready, sframe, sdata, busy}), 64'b11_00_00_00);
    end

    // Directed words, then back-to-back with i_valid held.
    send(10'h2A5, 0, t1);
    send(10'h003, 4, t1);
    send(10'h3FF, 3, t1);
    send(10'h001, 0, t2);
    check((t2 - t1) / 10 == W + 2 + P, "b2b_spacing", 64'((t2 - t1) / 10), 64'(W + 2 + P));

    // Random words with random idle gaps and scrambled data while busy.
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom), int'($urandom_range(0, 4)), t1);
      if (k % 8 == 0) begin
        send(W'($urandom), 0, t2);
        check((t2 - t1) / 10 == W + 2 + P, "b2b_spacing_rand", 64'((t2 - t1) / 10), 64'(W + 2 + P));
      end
    end

    // Reset during the 4th bit abandons the frame.
    send(10'h2A5, 2, t1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check({ready, sframe, sdata, busy} == 8'b11_00_00_00, "async_reset_midframe",
             64'({ready, sframe, sdata, busy}), 64'b11_00_00_00);
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(10'h15A, 0, t1);
    send(10'h2A5, 1, t1);

    repeat (W + 6) @(negedge clk);
    check(exp_q0.size() == 0 && exp_q1.size() == 0, "scoreboard_drained",
          64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
